// File: rtl/pipe_add_pkg.sv
// Shared constants and the per-stage payload for the pipelined adder.
// PIPE_ADD_OVF_EN adds the operand sign bits to the payload for overflow detection.
package pipe_add_pkg;

  localparam int unsigned DefaultWidth  = 16;
  localparam int unsigned DefaultStages = 4;
  // Upper bound on WIDTH; payload fields are sized to it and unused bits stay zero.
  localparam int unsigned MaxWidth      = 64;

  typedef struct packed {
    logic [MaxWidth-1:0] a_rem;  // operand chunks not yet added
    logic [MaxWidth-1:0] b_rem;
    logic [MaxWidth-1:0] sum;    // completed lower sum chunks
    logic                carry;
`ifdef PIPE_ADD_OVF_EN
    logic                sign_a;
    logic                sign_b;
`endif
  } stage_payload_t;

endpackage

// File: rtl/pipe_add_stage.sv
// One pipeline stage: adds chunk Idx of the operands plus the incoming carry and registers the
// result with a valid bit; holds its contents while stalled downstream.
module pipe_add_stage
  import pipe_add_pkg::*;
#(
  parameter int unsigned Cw  = 4,
  parameter int unsigned Idx = 0
) (
  input  logic           clk_i,
  input  logic           rst_n,
  input  logic           valid_i,
  input  stage_payload_t pay_i,
  input  logic           ready_i,
  output logic           valid_o,
  output stage_payload_t pay_o
);

  localparam int unsigned Lsb = Idx * Cw;

  logic           valid_q;
  logic           load;
  logic [Cw:0]    chunk_sum;
  stage_payload_t pay_d, pay_q;

  assign load      = !valid_q || ready_i;
  assign chunk_sum = {1'b0, pay_i.a_rem[Lsb +: Cw]} + {1'b0, pay_i.b_rem[Lsb +: Cw]}
                   + {{Cw{1'b0}}, pay_i.carry};

  always_comb begin
    pay_d                   = pay_i;
    // Consumed operand chunks are cleared so only the remaining ones travel on.
    pay_d.a_rem[Lsb +: Cw]  = '0;
    pay_d.b_rem[Lsb +: Cw]  = '0;
    pay_d.sum[Lsb +: Cw]    = chunk_sum[Cw-1:0];
    pay_d.carry             = chunk_sum[Cw];
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else if (load) begin
      valid_q <= valid_i;
      if (valid_i) begin
        pay_q <= pay_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign pay_o   = pay_q;

endmodule

// File: rtl/pipe_add.sv
// Pipelined ripple adder: STAGES chunk adders of WIDTH/STAGES bits with valid/ready flow control.
// Define PIPE_ADD_OVF_EN to produce the signed overflow flag; otherwise ovf is tied low.
module pipe_add
  import pipe_add_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned STAGES = DefaultStages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned CW = WIDTH / STAGES;

  if (STAGES == 0 || (WIDTH % STAGES) != 0 || WIDTH > MaxWidth) begin : g_bad_cfg
    $error("pipe_add: need STAGES >= 1, WIDTH a multiple of STAGES, WIDTH <= %0d", MaxWidth);
  end

  logic [STAGES:0] vchain;
  logic [STAGES:0] ready;
  stage_payload_t  pay_in;
  stage_payload_t  pay [STAGES+1];

  always_comb begin
    pay_in                   = '0;
    pay_in.a_rem[WIDTH-1:0]  = a;
    pay_in.b_rem[WIDTH-1:0]  = b;
    pay_in.carry             = c_in;
`ifdef PIPE_ADD_OVF_EN
    pay_in.sign_a            = a[WIDTH-1];
    pay_in.sign_b            = b[WIDTH-1];
`endif
  end

  assign vchain[0] = in_valid;
  assign pay[0]    = pay_in;

  // ready_k = !v_k || ready_{k+1}, unrolled from the output end so no signal feeds itself.
  always_comb begin
    logic acc;
    acc           = out_ready;
    ready[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      acc      = acc || !vchain[k+1];
      ready[k] = acc;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_add_stage #(
      .Cw  (CW),
      .Idx (k)
    ) u_stage (
      .clk_i   (clk),
      .rst_n   (rst_n),
      .valid_i (vchain[k]),
      .pay_i   (pay[k]),
      .ready_i (ready[k+1]),
      .valid_o (vchain[k+1]),
      .pay_o   (pay[k+1])
    );
  end

  assign in_ready  = ready[0];
  assign out_valid = vchain[STAGES];
  assign sum       = pay[STAGES].sum[WIDTH-1:0];
  assign c_out     = pay[STAGES].carry;

`ifdef PIPE_ADD_OVF_EN
  assign ovf = (pay[STAGES].sign_a == pay[STAGES].sign_b) &&
               (pay[STAGES].sum[WIDTH-1] != pay[STAGES].sign_a);
`else
  assign ovf = 1'b0;
`endif

  // Operand fields are fully consumed by the last stage and upper sum bits are always zero.
  logic unused_last;
  assign unused_last = ^{pay[STAGES].a_rem, pay[STAGES].b_rem, pay[STAGES].sum};

endmodule

// File: tb/tb_pipe_add.sv
// Randomized and directed bench for pipe_add against a queue-based arithmetic reference model.
module tb_pipe_add;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf;
  logic [W-1:0] a, b, sum;

  always #5 clk = ~clk;

  pipe_add #(
    .WIDTH  (W),
    .STAGES (S)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_cons   = 0;
  logic consumed;
  logic [W+1:0] exp_q [$];  // {ovf, c_out, sum} per accepted beat, in order

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] full;
    logic       v;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    v    = 1'b0;
`ifdef PIPE_ADD_OVF_EN
    v = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
`endif
    return {v, full};
  endfunction

  // Drive one cycle's inputs, then score the handshakes that the next rising edge completes.
  task automatic step(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic ordy);
    logic [W+1:0] e;
    @(negedge clk);
    in_valid  = v;
    a         = ta;
    b         = tb;
    c_in      = tc;
    out_ready = ordy;
    #1;
    consumed = 1'b0;
    // Beats in flight equal occupied stages, so the input is ready unless all are full and stalled.
    check("in_ready", 64'(in_ready), 64'((exp_q.size() < S) || ordy));
    if (out_valid && ordy) begin
      check("result_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sum", 64'(sum), 64'(e[W-1:0]));
        check("c_out", 64'(c_out), 64'(e[W]));
        check("ovf", 64'(ovf), 64'(e[W+1]));
      end
      consumed = 1'b1;
      n_cons++;
    end
    if (v && in_ready) begin
      exp_q.push_back(model(ta, tb, tc));
      n_acc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] da [4] = '{16'hFFFF, 16'h0000, 16'h7FFF, 16'h0009};
    logic [W-1:0] db [4] = '{16'h0001, 16'h0000, 16'h0001, 16'h0009};
    logic         dc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int first, base, cnt;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_c_out", 64'(c_out), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Latency from an empty pipe.
    step(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b1);
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      if (out_valid && first == 0) first = i;
    end
    check("latency", 64'(first), 64'(S));

    // Carry ripple, carry-in and overflow corner cases.
    for (int i = 0; i < 4; i++) step(1'b1, da[i], db[i], dc[i], 1'b1);
    idle(S + 2);
    check("directed_drained", 64'(exp_q.size()), 64'(0));

    // Eight back-to-back beats must emerge on eight consecutive cycles.
    cnt = 0;
    for (int i = 0; i < 8 + S + 2; i++) begin
      if (i < 8) step(1'b1, 16'($urandom_range(16'hFFFF)), 16'($urandom_range(16'hFFFF)),
                      1'($urandom_range(1)), 1'b1);
      else idle(1);
      if (consumed && i >= S && i < S + 8) cnt++;
    end
    check("b2b_consecutive", 64'(cnt), 64'(8));

    // Stall with continuous input: exactly S beats fit, then drain in order.
    base = n_acc;
    for (int i = 0; i < 6; i++)
      step(1'b1, 16'($urandom_range(16'hFFFF)), 16'($urandom_range(16'hFFFF)),
           1'($urandom_range(1)), 1'b0);
    check("stall_accepted", 64'(n_acc - base), 64'(S));
    check("stall_in_ready", 64'(in_ready), 64'(0));
    base = n_cons;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("stall_drained", 64'(n_cons - base), 64'(S));

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1000 + 16'(i), 16'h0101, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_out_valid", 64'(out_valid), 64'(1));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    base = n_cons;
    idle(8);
    check("no_stale_results", 64'(n_cons - base), 64'(0));
    step(1'b1, 16'h1234, 16'h1111, 1'b1, 1'b1);
    base = n_cons;
    idle(S + 2);
    check("post_rst_beat", 64'(n_cons - base), 64'(1));

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(1)), 16'($urandom_range(16'hFFFF)), 16'($urandom_range(16'hFFFF)),
           1'($urandom_range(1)), 1'($urandom_range(3) != 0));
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
    check("random_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
